// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the CPU core fetch stage.
//
// Holds the fetch PC and moves it forward on each falling clock edge. At each
// edge the highest-priority request wins, in this order:
//   exception entry > exception return > redirect (new or buffered)
//   > sequential advance > hold
// A redirect that arrives while fetch is stalled is kept in a one-entry buffer
// until the stall is released. A newer stalled redirect replaces the buffered
// one. EPC holds the PC that was current when the exception was taken.
//
// Optional build macro:
//   PC_ALIGN_CHECK_EN -- a redirect target that is not STEP-aligned is trapped
//                        when it would be loaded. The unit then takes the
//                        exception vector and pulses adr_err. When the macro
//                        is undefined, the low target bits are cleared on
//                        load and adr_err is tied low.
//
// Parameters:
//   WIDTH      PC width in bits (>= 8)
//   RESET_ADDR PC value while reset is asserted
//   EXC_ADDR   exception vector
//   STEP       sequential increment (a power of two)
//
// Ports:
//   clk             in   clock; all state changes on the falling edge
//   rst             in   asynchronous, active-high reset
//   stall           in   hold PC; suppresses advance and redirect application
//   redirect_valid  in   branch/jump taken this cycle
//   redirect_target in   redirect destination
//   exc_req         in   take exception (ignores stall)
//   eret            in   return from exception (ignores stall)
//   pc              out  current fetch PC (registered)
//   epc             out  saved exception PC (registered)
//   pending         out  a buffered redirect is waiting for stall release
//   adr_err         out  one-cycle pulse on a trapped misaligned redirect
// -----------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(0),
  parameter logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(4),
  parameter int unsigned      STEP       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             pending,
  output logic             adr_err
);

  // The low ALIGN_BITS bits of any legal fetch address are zero.
  localparam int unsigned      ALIGN_BITS = $clog2(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  // RUN: no buffered redirect. HELD: a redirect waits in pend_target_q.
  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             buf_valid;
  logic             load_en;
  logic [WIDTH-1:0] load_target;
`ifdef PC_ALIGN_CHECK_EN
  logic             adr_err_q, adr_err_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (exc_req || eret) begin
      // Exception entry and return both discard any buffered redirect.
      state_d = RUN;
    end else if (stall) begin
      if (redirect_valid) begin
        state_d = HELD;
      end
    end else begin
      // Unstalled: a buffered or new redirect is consumed now (or trapped).
      state_d = RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_valid = (state_q == HELD);
    pending   = buf_valid;
    // A new redirect takes precedence over the buffered target.
    load_en     = !stall && (redirect_valid || buf_valid);
    load_target = redirect_valid ? redirect_target : pend_target_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: PC, EPC, buffered target and trap pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
`ifdef PC_ALIGN_CHECK_EN
    adr_err_d     = 1'b0;
`endif

    if (exc_req) begin
      pc_d  = EXC_ADDR;
      epc_d = pc_q;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (stall) begin
      // The alignment check is deferred until load time, so a stalled
      // redirect is buffered as is.
      if (redirect_valid) begin
        pend_target_d = redirect_target;
      end
    end else if (load_en) begin
`ifdef PC_ALIGN_CHECK_EN
      if ((load_target & ALIGN_MASK) != '0) begin
        // A misaligned target is handled exactly like an exception entry.
        pc_d      = EXC_ADDR;
        epc_d     = pc_q;
        adr_err_d = 1'b1;
      end else begin
        pc_d = load_target;
      end
`else
      pc_d = load_target & ~ALIGN_MASK;
`endif
    end else begin
      // Wraps modulo 2^WIDTH.
      pc_d = pc_q + STEP_W;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_ADDR;
      epc_q         <= '0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      adr_err_q <= 1'b0;
    end else begin
      adr_err_q <= adr_err_d;
    end
  end

  assign adr_err = adr_err_q;
`else
  assign adr_err = 1'b0;
`endif

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps

module tb_pc_unit;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        pending;
  logic        adr_err;

  logic        stall16 = 1'b0;
  logic        rv16 = 1'b0;
  logic [15:0] tgt16 = 16'h0;
  logic        exc16 = 1'b0;
  logic        eret16 = 1'b0;
  logic [15:0] pc16;
  logic [15:0] epc16;
  logic        pending16;
  logic        adr_err16;

  int checks = 0;
  int errors = 0;

  // Reference model state, 32-bit instance.
  logic [31:0] m_pc, m_epc, m_ptgt;
  logic        m_pend, m_aerr;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_req(exc_req), .eret(eret),
    .pc(pc), .epc(epc), .pending(pending), .adr_err(adr_err)
  );

  pc_unit #(.WIDTH(16), .RESET_ADDR(16'h0000), .EXC_ADDR(16'h0004), .STEP(4)) dut16 (
    .clk(clk), .rst(rst), .stall(stall16), .redirect_valid(rv16),
    .redirect_target(tgt16), .exc_req(exc16), .eret(eret16),
    .pc(pc16), .epc(epc16), .pending(pending16), .adr_err(adr_err16)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ptgt = 32'h0; m_pend = 1'b0; m_aerr = 1'b0;
  endtask

  // One falling edge of the specification's priority rules.
  task automatic model_step(input logic s, input logic rv, input logic [31:0] t,
                            input logic e, input logic er);
    logic [31:0] tgt;
    m_aerr = 1'b0;
    if (e) begin
      m_epc = m_pc; m_pc = 32'h4; m_pend = 1'b0;
    end else if (er) begin
      m_pc = m_epc; m_pend = 1'b0;
    end else if (s) begin
      if (rv) begin m_pend = 1'b1; m_ptgt = t; end
    end else if (rv || m_pend) begin
      tgt = rv ? t : m_ptgt;
      m_pend = 1'b0;
      if (tgt % 4 != 0) begin
`ifdef PC_ALIGN_CHECK_EN
        m_epc = m_pc; m_pc = 32'h4; m_aerr = 1'b1;
`else
        m_pc = tgt - (tgt % 4);
`endif
      end else begin
        m_pc = tgt;
      end
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Called just after a falling edge: applies inputs, advances the model and
  // returns just after the next falling edge.
  task automatic drive(input logic s, input logic rv, input logic [31:0] t,
                       input logic e, input logic er);
    stall = s; redirect_valid = rv; redirect_target = t; exc_req = e; eret = er;
    model_step(s, rv, t, e, er);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    checks++; if (adr_err !== 1'b0) begin errors++; $display("FAIL reset_adr_err got %b want 0", adr_err); end
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 32'h0, 0, 0);
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, pc, 32'(i * 4)); end
    end
    checks++; if (epc !== 32'h0 || pending !== 1'b0) begin errors++; $display("FAIL seq_epc_pend got %h/%b want 0/0", epc, pending); end
  endtask

  task automatic test_stall_redirect();
    drive(0, 1, 32'h100, 0, 0);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL sr_setup got %h want 100", pc); end
    drive(1, 1, 32'h400, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc !== 32'h100 || pending !== 1'b1) begin errors++; $display("FAIL sr_hold%0d got %h/%b want 100/1", i, pc, pending); end
      if (i < 2) drive(1, 0, 32'h0, 0, 0);
    end
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc !== 32'h400 || pending !== 1'b0) begin errors++; $display("FAIL sr_release got %h/%b want 400/0", pc, pending); end
  endtask

  task automatic test_new_beats_pending();
    drive(1, 1, 32'h400, 0, 0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL nb_pend got %b want 1", pending); end
    drive(0, 1, 32'h800, 0, 0);
    checks++; if (pc !== 32'h800 || pending !== 1'b0) begin errors++; $display("FAIL nb_new got %h/%b want 800/0", pc, pending); end
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc !== 32'h804) begin errors++; $display("FAIL nb_after got %h want 804", pc); end
  endtask

  task automatic test_exception();
    drive(0, 1, 32'h200, 0, 0);
    drive(1, 1, 32'h300, 1, 0);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL exc_pc got %h want 4", pc); end
    checks++; if (epc !== 32'h200) begin errors++; $display("FAIL exc_epc got %h want 200", epc); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL exc_pending got %b want 0", pending); end
    drive(0, 0, 32'h0, 0, 1);
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL eret_pc got %h want 200", pc); end
    // Exception on the same edge a buffered target would be applied.
    drive(1, 1, 32'h500, 0, 0);
    drive(0, 0, 32'h0, 1, 0);
    checks++; if (pc !== 32'h4 || epc !== 32'h200 || pending !== 1'b0) begin errors++; $display("FAIL exc_vs_pend got %h/%h/%b want 4/200/0", pc, epc, pending); end
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL exc_discard got %h want 8", pc); end
    // A stalled eret still applies.
    drive(1, 0, 32'h0, 0, 1);
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL eret_stall got %h want 200", pc); end
  endtask

  task automatic test_align();
    drive(0, 1, 32'h100, 0, 0);
    drive(0, 1, 32'h402, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (pc !== 32'h4 || epc !== 32'h100 || adr_err !== 1'b1) begin errors++; $display("FAIL align_new got %h/%h/%b want 4/100/1", pc, epc, adr_err); end
`else
    checks++; if (pc !== 32'h400 || adr_err !== 1'b0) begin errors++; $display("FAIL align_new got %h/%b want 400/0", pc, adr_err); end
`endif
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (adr_err !== 1'b0) begin errors++; $display("FAIL align_pulse got %b want 0", adr_err); end
    drive(0, 1, 32'h100, 0, 0);
    drive(1, 1, 32'h402, 0, 0);
    checks++; if (pending !== 1'b1 || adr_err !== 1'b0 || pc !== 32'h100) begin errors++; $display("FAIL align_buf got %h/%b/%b want 100/1/0", pc, pending, adr_err); end
    drive(0, 0, 32'h0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (pc !== 32'h4 || epc !== 32'h100 || adr_err !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL align_pend got %h/%h/%b want 4/100/1", pc, epc, adr_err); end
`else
    checks++; if (pc !== 32'h400 || adr_err !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL align_pend got %h/%b want 400/0", pc, adr_err); end
`endif
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap32 got %h want 0", pc); end
  endtask

  task automatic test_wrap16_and_reset();
    stall16 = 1'b0; rv16 = 1'b1; tgt16 = 16'hFFFC;
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc16 !== 16'hFFFC) begin errors++; $display("FAIL w16_setup got %h want fffc", pc16); end
    rv16 = 1'b0;
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (pc16 !== 16'h0000) begin errors++; $display("FAIL w16_wrap got %h want 0000", pc16); end
    stall16 = 1'b1; rv16 = 1'b1; tgt16 = 16'h0400;
    drive(1, 1, 32'h600, 0, 0);
    rv16 = 1'b0;
    drive(1, 0, 32'h0, 0, 0);
    checks++; if (pending16 !== 1'b1 || pending !== 1'b1) begin errors++; $display("FAIL rst_pre got %b/%b want 1/1", pending16, pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pc16 !== 16'h0 || pending16 !== 1'b0) begin errors++; $display("FAIL rst_async16 got %h/%b want 0/0", pc16, pending16); end
    checks++; if (pc !== 32'h0 || pending !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL rst_async got %h/%b/%h want 0/0/0", pc, pending, epc); end
    #1 rst = 1'b0;
    stall16 = 1'b0;
    model_reset();
    stall = 1'b0; redirect_valid = 1'b0; exc_req = 1'b0; eret = 1'b0;
    model_step(0, 0, 32'h0, 0, 0);
    @(negedge clk); #1;
    checks++; if (pc !== 32'h4 || pc16 !== 16'h4 || pending !== 1'b0) begin errors++; $display("FAIL rst_release got %h/%h/%b want 4/4/0", pc, pc16, pending); end
  endtask

  task automatic test_random();
    logic s, rv, e, er;
    logic [31:0] t;
    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 2) == 0);
      e  = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       t = $urandom();
        1:       t = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
        default: t = $urandom() & 32'h0000_FFFC;
      endcase
      drive(s, rv, t, e, er);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc got %h want %h", i, pc, m_pc); end
      checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd%0d_epc got %h want %h", i, epc, m_epc); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd%0d_pending got %b want %b", i, pending, m_pend); end
      checks++; if (adr_err !== m_aerr) begin errors++; $display("FAIL rnd%0d_adr_err got %b want %b", i, adr_err, m_aerr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall_redirect();
    test_new_beats_pending();
    test_exception();
    test_align();
    test_wrap16_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle/pipelined CPU core, replacing the plain enable-gated PC register. Holds the fetch PC, advances it sequentially, and applies branch/jump redirects, exception entry and exception return with fixed priority. A one-entry pending-redirect buffer keeps a redirect that arrives while the fetch stage is stalled. An exception PC (EPC) register supports return.

## Interface
- WIDTH, 32, PC width in bits (≥ 8)
- RESET_ADDR, 0x0000_0000, PC value on reset (WIDTH bits)
- EXC_ADDR, 0x0000_0004, exception vector (WIDTH bits)
- STEP, 4, sequential increment
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC; sequential advance and redirect application suppressed
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  WIDTH  redirect destination
- exc_req  in  1  take exception
- eret  in  1  return from exception
- pc  out  WIDTH  current fetch PC (registered)
- epc  out  WIDTH  saved exception PC (registered)
- pending  out  1  buffered redirect waiting for stall release
- adr_err  out  1  one-cycle pulse: misaligned redirect trapped (macro only; else constant 0)

## Operation
- Priority per falling edge: exc_req > eret > redirect (new or pending) > sequential > hold.
- exc_req: pc <= EXC_ADDR, epc <= current pc, pending <= 0. Ignores stall.
- eret (no exc_req): pc <= epc, pending <= 0. Ignores stall.
- stall=1, redirect_valid=1: pend_target <= redirect_target, pending <= 1; pc holds. A newer redirect overwrites an older buffered one.
- stall=1, no redirect: pc and pending hold.
- stall=0, redirect_valid=1: pc <= redirect_target; pending <= 0 (new redirect beats buffered one).
- stall=0, pending=1, no new redirect: pc <= pend_target, pending <= 0.
- stall=0, otherwise: pc <= pc + STEP, modulo 2^WIDTH (e.g. 0xFFFF_FFFC + 4 -> 0x0000_0000).
- Two states: RUN (pending=0), HELD (pending=1). RUN->HELD on stall&redirect; HELD->RUN on !stall, exc_req or eret.

## Timing
- Reset (async, immediate): pc=RESET_ADDR, epc=0, pending=0, pend_target=0, adr_err=0.
- Reset released mid-operation: first falling edge after release evaluates normally from reset values.
- Latency: inputs sampled at falling edge N; pc/epc/pending/adr_err valid after edge N, one edge latency, no combinational input-to-output path.
- adr_err high for exactly one cycle; cleared on the next edge.
- exc_req on the same edge as a redirect applying a pending target: exception wins, buffered target discarded.

## Configuration
- PC_ALIGN_CHECK_EN defined: redirect target (new or pending) with a nonzero bit in log2(STEP) low bits is not applied; the unit behaves as exc_req (pc <= EXC_ADDR, epc <= current pc, pending <= 0) and pulses adr_err. Check applies when the target would be loaded, not when buffered.
- Undefined: low log2(STEP) bits of the target are forced to 0 on load; adr_err tied 0.

## Test plan
- Reset then 3 unstalled edges -> pc 0x0, 0x4, 0x8, 0xC; epc=0, pending=0.
- pc=0x100, stall=1 with redirect to 0x400 for one edge, stall held 2 more edges -> pc stays 0x100, pending=1; stall=0 -> pc=0x400, pending=0.
- pending=1 (0x400), stall=0 with new redirect 0x800 -> pc=0x800; pending=0.
- pc=0x200, exc_req with stall=1 and redirect to 0x300 -> pc=0x4, epc=0x200, pending=0; eret -> pc=0x200.
- WIDTH=16, pc=0xFFFC, unstalled edge -> pc=0x0000; assert rst mid-stall with pending=1 -> pc=RESET_ADDR, pending=0 immediately.
- Redirect to 0x402: with PC_ALIGN_CHECK_EN -> pc=0x4, epc=old pc, adr_err pulses one cycle; without -> pc=0x400, adr_err=0.
